// File: rtl/pulp_cg_pkg.sv
// -----------------------------------------------------------------------------
// pulp_cg_pkg : shared types and defaults for the automatic clock-gate controller
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package pulp_cg_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        IDLE_WAIT = 3'd1,
        QUIESCE   = 3'd2,
        GATED     = 3'd3,
        WAKE      = 3'd4
    } cg_state_e;

    localparam int unsigned DEFAULT_WAKE_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/pulp_clock_gating.sv
// -----------------------------------------------------------------------------
// pulp_clock_gating : latch-based integrated clock gate with scan enable
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pulp_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch_q;

    // Transparent while the clock is low so the enable can only change between pulses.
    always_latch begin
        if (!clk_i) begin
            en_latch_q = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch_q;

endmodule

`default_nettype wire

// File: rtl/pulp_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// pulp_clk_gate_ctrl : idle-detecting clock-gate controller with quiesce handshake
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pulp_clk_gate_ctrl
    import pulp_cg_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned WAKE_CYCLES = DEFAULT_WAKE_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               test_en_i,
    input  logic               cfg_en_i,
    input  logic [CNT_W-1:0]   cfg_idle_cycles_i,
    input  logic [NUM_REQ-1:0] busy_i,
    input  logic [NUM_REQ-1:0] wake_req_i,
    output logic               qreq_o,
    input  logic               qack_i,
    output logic               clk_en_o,
    output logic               gated_o,
    output logic               clk_o
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_en_q, clk_en_d;
    logic             qreq_q, qreq_d;
    logic             gated_q, gated_d;
    logic             act;
    logic             wake_any;

    assign wake_any = |wake_req_i;
    assign act      = (|busy_i) | wake_any;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
            qreq_q   <= 1'b0;
            gated_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clk_en_q <= clk_en_d;
            qreq_q   <= qreq_d;
            gated_q  <= gated_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clk_en_d = clk_en_q;
        qreq_d   = qreq_q;
        gated_d  = gated_q;

        case (state_q)
            RUN: begin
                // A still-high qack means the previous handshake has not closed yet.
                if (cfg_en_i && !act && !qack_i) begin
                    state_d = IDLE_WAIT;
                    cnt_d   = cfg_idle_cycles_i;
                end
            end

            IDLE_WAIT: begin
                if (act || !cfg_en_i) begin
                    state_d = RUN;
                end else if (cnt_q == '0) begin
                    state_d = QUIESCE;
                    qreq_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            QUIESCE: begin
                // Abort is checked first so late activity always keeps the clock.
                if (act || !cfg_en_i) begin
                    state_d = RUN;
                    qreq_d  = 1'b0;
                end else if (qack_i) begin
                    state_d  = GATED;
                    clk_en_d = 1'b0;
                    gated_d  = 1'b1;
                end
            end

            GATED: begin
                if (wake_any || !cfg_en_i) begin
                    state_d  = WAKE;
                    clk_en_d = 1'b1;
                    gated_d  = 1'b0;
                    cnt_d    = WAKE_LOAD;
                end
            end

            WAKE: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                    qreq_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d  = RUN;
                cnt_d    = '0;
                clk_en_d = 1'b1;
                qreq_d   = 1'b0;
                gated_d  = 1'b0;
            end
        endcase
    end

    assign qreq_o   = qreq_q;
    assign clk_en_o = clk_en_q;
    assign gated_o  = gated_q;

    pulp_clock_gating u_icg (
        .clk_i     (clk_i),
        .en_i      (clk_en_q),
        .test_en_i (test_en_i),
        .clk_o     (clk_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_pulp_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pulp_clk_gate_ctrl : directed self-checking bench for the clock-gate controller
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pulp_clk_gate_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       test_en_i;
    logic       cfg_en_i;
    logic [7:0] cfg_idle_cycles_i;
    logic [3:0] busy_i;
    logic [3:0] wake_req_i;
    logic       qreq_o;
    logic       qack_i;
    logic       clk_en_o;
    logic       gated_o;
    logic       clk_o;

    logic       qack_tie;
    logic       qack_man;
    logic [1:0] qack_pipe = 2'b00;
    int         n_clko = 0;
    int         n_chk  = 0;
    int         n_pass = 0;
    int         snap;

    always #5 clk_i = ~clk_i;

    // Domain model: acknowledges two cycles after the request when tied.
    always @(posedge clk_i) qack_pipe <= {qack_pipe[0], qreq_o};
    assign qack_i = qack_tie ? qack_pipe[1] : qack_man;

    always @(posedge clk_o) n_clko <= n_clko + 1;

    pulp_clk_gate_ctrl #(
        .NUM_REQ     (4),
        .CNT_W       (8),
        .WAKE_CYCLES (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .test_en_i         (test_en_i),
        .cfg_en_i          (cfg_en_i),
        .cfg_idle_cycles_i (cfg_idle_cycles_i),
        .busy_i            (busy_i),
        .wake_req_i        (wake_req_i),
        .qreq_o            (qreq_o),
        .qack_i            (qack_i),
        .clk_en_o          (clk_en_o),
        .gated_o           (gated_o),
        .clk_o             (clk_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rst_ni = 1'b0; test_en_i = 1'b0; cfg_en_i = 1'b0; cfg_idle_cycles_i = 8'd5;
        busy_i = '0; wake_req_i = '0; qack_tie = 1'b0; qack_man = 1'b0;

        // Reset state and free-running clock with gating disabled
        tick(2);
        chk("rst_clk_en", clk_en_o, 1);
        chk("rst_qreq",   qreq_o,   0);
        chk("rst_gated",  gated_o,  0);
        rst_ni = 1'b1;
        snap = n_clko;
        tick(5);
        chk("run_clk_en", clk_en_o, 1);
        chk("run_clko_edges", n_clko - snap, 5);

        // Idle hold-off of 5, handshake with 2-cycle acknowledge
        qack_tie = 1'b1; cfg_en_i = 1'b1; cfg_idle_cycles_i = 8'd5;
        tick(6);
        chk("qreq_not_early", qreq_o, 0);
        tick(1);
        chk("qreq_at_7", qreq_o, 1);
        tick(2);
        chk("qack_seen", qack_i, 1);
        chk("clk_en_before_gate", clk_en_o, 1);
        tick(1);
        chk("clk_en_gated", clk_en_o, 0);
        chk("gated_set", gated_o, 1);
        snap = n_clko;
        tick(5);
        chk("clko_flat", n_clko - snap, 0);
        chk("clko_level", clk_o, 0);

        // Wake on a one-cycle pulse of wake_req_i[2]
        wake_req_i = 4'b0100;
        tick(1);
        wake_req_i = '0;
        chk("wake_clk_en", clk_en_o, 1);
        chk("wake_gated", gated_o, 0);
        chk("wake_qreq_1", qreq_o, 1);
        tick(1);
        chk("wake_qreq_2", qreq_o, 1);
        tick(1);
        chk("wake_qreq_drop", qreq_o, 0);
        qack_tie = 1'b0; qack_man = 1'b1; cfg_idle_cycles_i = 8'd0;
        tick(3);
        chk("qack_blocks_regate", qreq_o, 0);
        chk("qack_blocks_clk_en", clk_en_o, 1);

        // busy during countdown returns to RUN without a request
        qack_man = 1'b0; cfg_en_i = 1'b0;
        tick(1);
        cfg_en_i = 1'b1; cfg_idle_cycles_i = 8'd5;
        tick(3);
        busy_i = 4'b0001;
        tick(1);
        chk("busy_abort_qreq", qreq_o, 0);
        tick(8);
        chk("busy_hold_qreq", qreq_o, 0);

        // Abort beats a same-cycle acknowledge in QUIESCE
        busy_i = '0; cfg_idle_cycles_i = 8'd0;
        tick(1);
        chk("idle0_iw_qreq", qreq_o, 0);
        tick(1);
        chk("idle0_quiesce", qreq_o, 1);
        busy_i = 4'b0010; qack_man = 1'b1;
        tick(1);
        chk("abort_qreq", qreq_o, 0);
        chk("abort_clk_en", clk_en_o, 1);
        chk("abort_gated", gated_o, 0);

        // Gate with zero hold-off, then ungate by clearing cfg_en_i
        busy_i = '0; qack_man = 1'b0;
        tick(1);
        chk("idle0_b_iw", qreq_o, 0);
        tick(1);
        chk("idle0_b_quiesce", qreq_o, 1);
        qack_man = 1'b1;
        tick(1);
        chk("gate2_clk_en", clk_en_o, 0);
        chk("gate2_gated", gated_o, 1);
        qack_man = 1'b0; cfg_en_i = 1'b0;
        tick(1);
        chk("cfgoff_clk_en", clk_en_o, 1);
        chk("cfgoff_qreq_1", qreq_o, 1);
        tick(1);
        chk("cfgoff_qreq_2", qreq_o, 1);
        tick(1);
        chk("cfgoff_qreq_drop", qreq_o, 0);
        snap = n_clko;
        tick(3);
        chk("cfgoff_clk_running", n_clko - snap, 3);
        chk("cfgoff_stays_on", clk_en_o, 1);

        // Gate again, then scan enable forces the clock through
        cfg_en_i = 1'b1;
        tick(2);
        qack_man = 1'b1;
        tick(1);
        qack_man = 1'b0;
        chk("gate3_gated", gated_o, 1);
        test_en_i = 1'b1;
        snap = n_clko;
        tick(4);
        chk("test_en_clko", n_clko - snap, 4);
        chk("test_en_gated", gated_o, 1);
        test_en_i = 1'b0;
        snap = n_clko;
        tick(2);
        chk("test_en_off_flat", n_clko - snap, 0);

        // Asynchronous reset while gated
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_clk_en", clk_en_o, 1);
        chk("arst_qreq",   qreq_o,   0);
        chk("arst_gated",  gated_o,  0);
        cfg_en_i = 1'b0;
        tick(1);
        rst_ni = 1'b1;
        snap = n_clko;
        tick(3);
        chk("post_rst_clko", n_clko - snap, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
